// File: rtl/ame_matrix_builder.sv
// Accumulates the symmetric normal-equation matrix A (c*c^T) and vector B (c*r)
// of an affine motion estimate over one frame of coefficient samples.
module ame_matrix_builder #(
  parameter int COMP_DATA_BITS = 64,
  parameter int COEF_BITS      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  comp_init_i,
  output logic                                  comp_done_o,
  input  logic                                  affine_param6_i,
  input  logic                                  samp_valid_i,
  output logic                                  samp_ready_o,
  input  logic                                  samp_last_i,
  input  logic [5:0][COEF_BITS-1:0]             samp_coef_i,
  input  logic [COEF_BITS-1:0]                  samp_resi_i,
  output logic [5:0][6:0][COMP_DATA_BITS-1:0]   comp_data_o,
  output logic [1:0]                            dbg_state_o
);

  localparam int PW = 2 * COEF_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  logic   mode6_q;
  logic   flush_cnt_q;
  logic   prod_vld_q;
  logic   accept;
  logic   clr;

  // Sample handshake: a sample transfers on a rising edge where samp_valid_i and
  // samp_ready_o are both high; samp_ready_o is high exactly while in ACCUM.
  assign accept      = samp_valid_i && samp_ready_o;
  assign clr         = (state_q == S_IDLE) && comp_init_i;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      samp_ready_o <= 1'b0;
      comp_done_o  <= 1'b0;
      mode6_q      <= 1'b1;
      flush_cnt_q  <= 1'b0;
      prod_vld_q   <= 1'b0;
    end else begin
      comp_done_o <= 1'b0;
      prod_vld_q  <= accept;
      case (state_q)
        S_IDLE: begin
          if (comp_init_i) begin
            mode6_q      <= affine_param6_i;
            samp_ready_o <= 1'b1;
            state_q      <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept && samp_last_i) begin
            samp_ready_o <= 1'b0;
            flush_cnt_q  <= 1'b0;
            state_q      <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Two cycles let the last product reach its accumulator before DONE.
          if (flush_cnt_q) begin
            comp_done_o <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            flush_cnt_q <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // In 4-parameter mode the translation-free lanes c0/c1 are zeroed at the source.
  logic signed [CW_FIX(COEF_BITS)-1:0] coef [6];
  logic signed [COEF_BITS-1:0]         resi;
  assign resi = samp_resi_i;

  for (genvar k = 0; k < 6; k++) begin : g_coef
    if (k < 2) begin : g_gate
      assign coef[k] = mode6_q ? samp_coef_i[k] : '0;
    end else begin : g_pass
      assign coef[k] = samp_coef_i[k];
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_row
    for (genvar j = 0; j < 7; j++) begin : g_col
      if (j == 6 || j >= i) begin : g_cell
        logic signed [COEF_BITS-1:0]      op_b;
        logic signed [PW-1:0]             a_ext;
        logic signed [PW-1:0]             b_ext;
        logic signed [PW-1:0]             prod_q;
        logic signed [COMP_DATA_BITS-1:0] acc_q;

        if (j == 6) begin : g_b
          assign op_b = resi;
        end else begin : g_b
          assign op_b = coef[j];
        end

        assign a_ext = PW'(coef[i]);
        assign b_ext = PW'(op_b);

        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            prod_q <= '0;
            acc_q  <= '0;
          end else begin
            if (accept) prod_q <= a_ext * b_ext;
            if (clr)             acc_q <= '0;
            else if (prod_vld_q) acc_q <= acc_q + COMP_DATA_BITS'(prod_q);
          end
        end

        assign comp_data_o[i][j] = acc_q;
      end else begin : g_mirror
        assign comp_data_o[i][j] = g_row[j].g_col[i].g_cell.acc_q;
      end
    end
  end

  function automatic int CW_FIX(input int w);
    return w;
  endfunction

endmodule

// File: tb/tb_ame_matrix_builder.sv
// Directed and randomized frames for ame_matrix_builder, checked against a
// behavioural sum-of-outer-products model.
module tb_ame_matrix_builder;

  localparam int DW = 64;
  localparam int CW = 16;

  logic                        clk_i;
  logic                        rst_n_i;
  logic                        comp_init_i;
  logic                        comp_done_o;
  logic                        affine_param6_i;
  logic                        samp_valid_i;
  logic                        samp_ready_o;
  logic                        samp_last_i;
  logic [5:0][CW-1:0]          samp_coef_i;
  logic [CW-1:0]               samp_resi_i;
  logic [5:0][6:0][DW-1:0]     comp_data_o;
  logic [1:0]                  dbg_state_o;

  ame_matrix_builder #(.COMP_DATA_BITS(DW), .COEF_BITS(CW)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .comp_init_i     (comp_init_i),
    .comp_done_o     (comp_done_o),
    .affine_param6_i (affine_param6_i),
    .samp_valid_i    (samp_valid_i),
    .samp_ready_o    (samp_ready_o),
    .samp_last_i     (samp_last_i),
    .samp_coef_i     (samp_coef_i),
    .samp_resi_i     (samp_resi_i),
    .comp_data_o     (comp_data_o),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]      exp_q[$];
  logic [5:0][CW-1:0] s_coef_q[$];
  logic [CW-1:0]      s_resi_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: A = sum c*c^T, B = sum c*r over the frame, wrapping at 64 bits.
  task automatic build_model(input bit mode6);
    longint a [6][7];
    longint c [6];
    longint r;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++) a[i][j] = 0;
    for (int k = 0; k < s_coef_q.size(); k++) begin
      for (int i = 0; i < 6; i++)
        c[i] = (!mode6 && i < 2) ? 0 : longint'($signed(s_coef_q[k][i]));
      r = longint'($signed(s_resi_q[k]));
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) a[i][j] += c[i] * c[j];
        a[i][6] += c[i] * r;
      end
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++) exp_q.push_back(a[i][j]);
  endtask

  task automatic check_matrix(input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++) begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d][%0d]", tag, i, j), comp_data_o[i][j], e);
      end
  endtask

  task automatic drive_junk();
    samp_coef_i = {$urandom, $urandom, $urandom};
    samp_resi_i = CW'($urandom);
    samp_last_i = 1'($urandom);
  endtask

  // Called one step after a rising edge while the DUT is idle.
  task automatic start_frame(input bit mode6, input int idle_junk);
    for (int k = 0; k < idle_junk; k++) begin
      samp_valid_i = 1'b1;
      drive_junk();
      @(posedge clk_i); #1;
    end
    samp_valid_i    = 1'b1;
    drive_junk();
    comp_init_i     = 1'b1;
    affine_param6_i = mode6;
    @(posedge clk_i); #1;
    comp_init_i     = 1'b0;
    samp_valid_i    = 1'b0;
    affine_param6_i = 1'($urandom);
    check("init_ready", 64'(samp_ready_o), 64'd1);
    check("init_clear", 64'(comp_data_o == '0), 64'd1);
  endtask

  // Sends the queued samples; returns in the cycle comp_done_o must be high.
  task automatic send_frame(input string tag, input int gap_max, input bit inject_init);
    int n;
    int gaps;
    int waited;
    n = s_coef_q.size();
    for (int k = 0; k < n; k++) begin
      gaps = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
      if (inject_init && k == 1 && gaps == 0) gaps = 1;
      for (int g = 0; g < gaps; g++) begin
        samp_valid_i    = 1'b0;
        drive_junk();
        comp_init_i     = inject_init && (k == 1) && (g == 0);
        affine_param6_i = 1'($urandom);
        @(posedge clk_i); #1;
      end
      comp_init_i  = 1'b0;
      samp_valid_i = 1'b1;
      samp_coef_i  = s_coef_q[k];
      samp_resi_i  = s_resi_q[k];
      samp_last_i  = (k == n - 1);
      waited = 0;
      while (samp_ready_o !== 1'b1 && waited < 20) begin
        @(posedge clk_i); #1;
        waited++;
      end
      check($sformatf("%s_accept_wait%0d", tag, k), 64'(waited), 64'd0);
      @(posedge clk_i); #1;
    end
    // Cycle T+1: flushing, a presented sample must be refused.
    samp_valid_i = 1'b1;
    drive_junk();
    samp_last_i  = 1'b1;
    check({tag, "_flush_ready"}, 64'(samp_ready_o), 64'd0);
    check({tag, "_done_t1"}, 64'(comp_done_o), 64'd0);
    @(posedge clk_i); #1;
    check({tag, "_done_t2"}, 64'(comp_done_o), 64'd0);
    samp_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check({tag, "_done_t3"}, 64'(comp_done_o), 64'd1);
    check_matrix(tag);
  endtask

  // Moves to the idle cycle after DONE and checks the pulse ended and data held.
  task automatic end_frame(input string tag, input logic [63:0] held_exp);
    @(posedge clk_i); #1;
    check({tag, "_done_pulse"}, 64'(comp_done_o), 64'd0);
    check({tag, "_hold55"}, comp_data_o[5][5], held_exp);
  endtask

  task automatic push_sample(input logic [5:0][CW-1:0] c, input logic [CW-1:0] r);
    s_coef_q.push_back(c);
    s_resi_q.push_back(r);
  endtask

  task automatic clear_samples();
    s_coef_q.delete();
    s_resi_q.delete();
  endtask

  task automatic random_frame(input string tag, input bit mode6, input int gap_max,
                              input bit inject_init, input int idle_junk);
    int n;
    logic [63:0] h;
    clear_samples();
    n = int'($urandom_range(8, 1));
    for (int k = 0; k < n; k++) push_sample({$urandom, $urandom, $urandom}, CW'($urandom));
    build_model(mode6);
    h = exp_q[5 * 7 + 5];
    start_frame(mode6, idle_junk);
    send_frame(tag, gap_max, inject_init);
    end_frame(tag, h);
  endtask

  initial begin
    rst_n_i = 1'b0;
    comp_init_i = 1'b0;
    affine_param6_i = 1'b0;
    samp_valid_i = 1'b0;
    samp_last_i = 1'b0;
    samp_coef_i = '0;
    samp_resi_i = '0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_done", 64'(comp_done_o), 64'd0);
    check("rst_ready", 64'(samp_ready_o), 64'd0);
    check("rst_data_zero", 64'(comp_data_o == '0), 64'd1);
    #2 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Single sample, 6-parameter.
    clear_samples();
    push_sample({16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 16'd7);
    build_model(1'b1);
    start_frame(1'b1, 0);
    send_frame("single", 0, 1'b0);
    check("single_a25", comp_data_o[2][5], 64'd18);
    check("single_a52", comp_data_o[5][2], 64'd18);
    check("single_a55", comp_data_o[5][5], 64'd36);
    check("single_b0", comp_data_o[0][6], 64'd7);
    end_frame("single", 64'd36);

    // Back-to-back pair, started the cycle after DONE.
    clear_samples();
    push_sample({6{16'd1}}, 16'd1);
    push_sample({6{16'hffff}}, 16'd2);
    build_model(1'b1);
    start_frame(1'b1, 0);
    send_frame("pair", 0, 1'b0);
    check("pair_a00", comp_data_o[0][0], 64'd2);
    check("pair_a31", comp_data_o[3][1], 64'd2);
    check("pair_b4", comp_data_o[4][6], 64'hffff_ffff_ffff_ffff);
    end_frame("pair", 64'd2);

    // 4-parameter frame with junk valid while idle.
    clear_samples();
    push_sample({16'd4, 16'd3, 16'd2, 16'd1, 16'd9, 16'd9}, 16'd1);
    build_model(1'b0);
    start_frame(1'b0, 2);
    send_frame("p4", 0, 1'b0);
    check("p4_a00", comp_data_o[0][0], 64'd0);
    check("p4_a15", comp_data_o[1][5], 64'd0);
    check("p4_b1", comp_data_o[1][6], 64'd0);
    check("p4_a34", comp_data_o[3][4], 64'd6);
    check("p4_b5", comp_data_o[5][6], 64'd4);
    end_frame("p4", 64'd16);

    // Valid gaps plus a comp_init_i pulse in the middle of ACCUM.
    random_frame("gapinit", 1'b1, 2, 1'b1, 1);

    // Extreme negative values over four samples.
    clear_samples();
    for (int k = 0; k < 4; k++) push_sample({6{16'h8000}}, 16'h8000);
    build_model(1'b1);
    start_frame(1'b1, 0);
    send_frame("extreme", 0, 1'b0);
    check("extreme_a13", comp_data_o[1][3], 64'h1_0000_0000);
    check("extreme_b2", comp_data_o[2][6], 64'h1_0000_0000);
    end_frame("extreme", 64'h1_0000_0000);

    for (int f = 0; f < 6; f++)
      random_frame($sformatf("rand%0d", f), 1'($urandom), int'($urandom_range(2, 0)),
                   1'($urandom), int'($urandom_range(2, 0)));

    // Reset in the middle of ACCUM.
    start_frame(1'b1, 0);
    samp_valid_i = 1'b1;
    samp_coef_i  = {6{16'd1}};
    samp_resi_i  = 16'd1;
    samp_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    samp_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("prerst_a55", comp_data_o[5][5], 64'd3);
    #3 rst_n_i = 1'b0;
    #1;
    check("midrst_data_zero", 64'(comp_data_o == '0), 64'd1);
    check("midrst_ready", 64'(samp_ready_o), 64'd0);
    check("midrst_done", 64'(comp_done_o), 64'd0);
    #2 rst_n_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      samp_valid_i = 1'b1;
      drive_junk();
      samp_last_i  = 1'b1;
      @(posedge clk_i); #1;
      check($sformatf("postrst_done%0d", k), 64'(comp_done_o), 64'd0);
      check($sformatf("postrst_ready%0d", k), 64'(samp_ready_o), 64'd0);
    end
    samp_valid_i = 1'b0;
    @(posedge clk_i); #1;

    random_frame("recover", 1'b1, 1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
